vector_multiply_stage: RTL and testbench

VECTOR_MULTIPLY_STAGE -- requirements
Module: vector_multiply_stage

---
 rtl/vector_multiply_stage.sv | 108 ++++++++++
 tb/tb_vector_multiply_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_multiply_stage.sv
// ---------------------------------------------------------------------------
// vector_multiply_stage
//
// Lane-wise unsigned multiplier with two register stages and a valid/ready
// handshake on both sides. Each cycle it can take one pair of N-lane operand
// vectors and produce N full-width (2*W) products. The products feed an
// adder tree directly.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   in_valid   operand vectors a_flat/b_flat are valid
//   in_ready   stage can accept operands this cycle
//   a_flat     operand A, lane i at [i*W +: W]
//   b_flat     operand B, same packing
//   out_valid  out_flat holds a valid product vector
//   out_ready  downstream accepts this cycle
//   out_flat   products, lane i at [i*2W +: 2W]
// ---------------------------------------------------------------------------
module vector_multiply_stage #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       a_flat,
  input  logic [N*W-1:0]       b_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*2*W-1:0]     out_flat
);

  // Full-width unsigned lane product; operands are zero-extended so the
  // multiply is evaluated at 2*W bits and can never truncate.
  function automatic logic [2*W-1:0] lane_mul(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    a_ext = {{W{1'b0}}, a};
    b_ext = {{W{1'b0}}, b};
    return a_ext * b_ext;
  endfunction

  logic [N*W-1:0]   a_p1;
  logic [N*W-1:0]   b_p1;
  logic             vld_p1;
  logic [N*2*W-1:0] prod_p1;
  logic [N*2*W-1:0] prod_p2;
  logic             vld_p2;

  logic s2_load;
  logic s2_take;
  logic in_fire;

  // S2 refills whenever S1 holds data and S2 is empty or draining this edge.
  // in_ready therefore depends combinationally on out_ready through both
  // stages, which is what allows a full pipeline to shift in a single edge.
  assign s2_load  = vld_p1 && (!vld_p2 || out_ready);
  assign s2_take  = vld_p2 && out_ready;
  assign in_ready = !vld_p1 || s2_load;
  assign in_fire  = in_valid && in_ready;

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_p1 <= a_flat;
      b_p1 <= b_flat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_comb begin
    prod_p1 = '0;
    for (int i = 0; i < N; i++) begin
      prod_p1[i*2*W +: 2*W] = lane_mul(a_p1[i*W +: W], b_p1[i*W +: W]);
    end
  end

  // ---- Stage 2: product register ----
  // The product register is cleared by reset because out_flat must read 0
  // while reset is held; otherwise it only changes when S2 loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      prod_p2 <= '0;
    end else if (s2_load) begin
      vld_p2  <= 1'b1;
      prod_p2 <= prod_p1;
    end else if (s2_take) begin
      vld_p2  <= 1'b0;
    end
  end

  assign out_valid = vld_p2;
  assign out_flat  = prod_p2;

endmodule

// File: tb/tb_vector_multiply_stage.sv
// ---------------------------------------------------------------------------
// tb_vector_multiply_stage
//
// Self-checking bench for vector_multiply_stage. Stimulus is driven and
// outputs sampled on the falling clock edge. Expected products come from a
// lane-wise arithmetic model; delivered vectors are collected in a FIFO so
// ordering can be compared against what was fed in.
// ---------------------------------------------------------------------------
module tb_vector_multiply_stage;
  localparam int N = 4;
  localparam int W = 8;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     a_flat;
  logic [N*W-1:0]     b_flat;
  logic               out_valid;
  logic               out_ready;
  logic [N*2*W-1:0]   out_flat;

  int checks;
  int errors;
  int acc_cnt;
  logic [N*2*W-1:0] got_q[$];

  vector_multiply_stage #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_flat   (a_flat),
    .b_flat   (b_flat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_flat (out_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each lane is the plain integer product of its operands.
  function automatic logic [N*2*W-1:0] model_prod(input logic [N*W-1:0] a,
                                                  input logic [N*W-1:0] b);
    logic [N*2*W-1:0] r;
    int unsigned p;
    r = '0;
    for (int i = 0; i < N; i++) begin
      p = int'(a[i*W +: W]) * int'(b[i*W +: W]);
      r[i*2*W +: 2*W] = p[2*W-1:0];
    end
    return r;
  endfunction

  // Transfer recorder: counts accepted inputs, queues delivered outputs.
  always @(posedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) got_q.push_back(out_flat);
    end
  end

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_flat = '0; b_flat = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_flat !== '0) begin errors++; $display("FAIL reset_out_flat: got %h want 0", out_flat); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  // One vector, out_ready=1: visible two falling edges after being driven,
  // a single out_valid pulse, data held afterwards.
  task automatic single_vector(input string name, input logic [N*W-1:0] a,
                               input logic [N*W-1:0] b, input logic [N*2*W-1:0] want);
    out_ready = 1'b1;
    a_flat = a; b_flat = b; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    @(negedge clk);
    in_valid = 1'b0; a_flat = '0; b_flat = '0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid: got %b want 0", name, out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
    checks++;
    if (out_flat !== want) begin errors++; $display("FAIL %s_data: got %h want %h", name, out_flat, want); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse: got %b want 0", name, out_valid); end
    checks++;
    if (out_flat !== want) begin errors++; $display("FAIL %s_hold: got %h want %h", name, out_flat, want); end
  endtask

  task automatic test_basic();
    logic [N*2*W-1:0] want;
    want = {16'd32, 16'd21, 16'd12, 16'd5};
    single_vector("basic", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, want);
  endtask

  task automatic test_max();
    logic [N*2*W-1:0] want;
    int sum;
    want = {N{16'd65025}};
    single_vector("max", {N{8'd255}}, {N{8'd255}}, want);
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(out_flat[i*2*W +: 2*W]);
    checks++;
    if (sum !== 260100) begin errors++; $display("FAIL max_sum: got %0d want 260100", sum); end
  endtask

  task automatic test_zero_edge();
    logic [N*2*W-1:0] want;
    want = {16'd0, 16'd255, 16'd255, 16'd0};
    single_vector("zero_edge", {8'd0, 8'd255, 8'd1, 8'd0}, {8'd9, 8'd1, 8'd255, 8'd0}, want);
  endtask

  task automatic test_streaming();
    logic [N*W-1:0]   a_v[8];
    logic [N*W-1:0]   b_v[8];
    logic [N*2*W-1:0] exp_v[8];
    for (int i = 0; i < 8; i++) begin
      a_v[i] = $urandom; b_v[i] = $urandom;
      exp_v[i] = model_prod(a_v[i], b_v[i]);
    end
    out_ready = 1'b1;
    // Falling edge c after the first drive: vector c-2 is on the output.
    for (int c = 0; c <= 10; c++) begin
      if (c < 8) begin
        a_flat = a_v[c]; b_flat = b_v[c]; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 1) begin
        checks++;
        if (out_valid !== (c >= 2 && c <= 9)) begin
          errors++; $display("FAIL stream_valid[%0d]: got %b want %b", c, out_valid, (c >= 2 && c <= 9));
        end
        if (c >= 2 && c <= 9) begin
          checks++;
          if (out_flat !== exp_v[c-2]) begin
            errors++; $display("FAIL stream_data[%0d]: got %h want %h", c - 2, out_flat, exp_v[c-2]);
          end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0]   a_v[3];
    logic [N*W-1:0]   b_v[3];
    logic [N*2*W-1:0] exp_v[3];
    logic [N*2*W-1:0] got;
    int start_acc;
    int waited;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = $urandom; b_v[i] = $urandom;
      exp_v[i] = model_prod(a_v[i], b_v[i]);
    end
    got_q.delete();
    start_acc = acc_cnt;
    out_ready = 1'b0;
    a_flat = a_v[0]; b_flat = b_v[0]; in_valid = 1'b1;
    @(negedge clk);
    a_flat = a_v[1]; b_flat = b_v[1];
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_ready: got %b want 1", in_ready); end
    @(negedge clk);
    a_flat = a_v[2]; b_flat = b_v[2];
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_third_blocked[%0d]: got %b want 0", c, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_flat !== exp_v[0]) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", c, out_valid, out_flat, exp_v[0]);
      end
      if (c < 5) @(negedge clk);
    end
    checks++;
    if (acc_cnt - start_acc !== 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", acc_cnt - start_acc); end
    // Release with a full pipeline: consume and accept happen on the same edge.
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_shift_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (got_q.size() < 3 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (got_q.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (got_q.size() > 0) ? got_q.pop_front() : '0;
      checks++;
      if (got !== exp_v[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got, exp_v[i]); end
    end
    @(negedge clk);
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL bp_extra: got %0d extra want 0", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [N*W-1:0]   a;
    logic [N*W-1:0]   b;
    logic [N*2*W-1:0] want;
    out_ready = 1'b0;
    a_flat = $urandom; b_flat = $urandom; in_valid = 1'b1;
    @(negedge clk);
    a_flat = $urandom; b_flat = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_inflight: got %b want 1", out_valid); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid: got %b want 0", out_valid); end
    checks++;
    if (out_flat !== '0) begin errors++; $display("FAIL rm_async_flat: got %h want 0", out_flat); end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d]: got %b want 0", c, out_valid); end
    end
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL rm_stale_count: got %0d want 0", got_q.size()); end
    a = $urandom; b = $urandom;
    want = model_prod(a, b);
    single_vector("rm_after", a, b, want);
  endtask

  initial begin
    checks = 0; errors = 0; acc_cnt = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero_edge();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
